// File: rtl/johnson_phase_sequencer_if.sv
// Host-side command/status bundle for johnson_phase_sequencer.
// The host (master) issues step commands, presets, HOLD and STOP.
// The sequencer (slave) returns the phase register and run status.
interface johnson_phase_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic             CMD_VALID;
   logic             CMD_READY;
   logic             CMD_DIR;
   logic [CNT_W-1:0] CMD_STEPS;
   logic             PRESET_VALID;
   logic [WIDTH-1:0] PRESET_VAL;
   logic             HOLD;
   logic             STOP;
   logic [WIDTH-1:0] Q;
   logic             BUSY;
   logic             DONE;
   logic [CNT_W-1:0] REMAIN;
   logic             ERR;

   modport master (
      output CMD_VALID, CMD_DIR, CMD_STEPS, PRESET_VALID, PRESET_VAL, HOLD, STOP,
      input  CMD_READY, Q, BUSY, DONE, REMAIN, ERR
   );

   modport slave (
      input  CMD_VALID, CMD_DIR, CMD_STEPS, PRESET_VALID, PRESET_VAL, HOLD, STOP,
      output CMD_READY, Q, BUSY, DONE, REMAIN, ERR
   );
endinterface

// File: rtl/johnson_phase_sequencer.sv
// Command-driven controller for a WIDTH-stage Johnson (twisted-ring) phase
// register. Runs forward or reverse for a programmed step count, or
// continuously when the count is 0, with HOLD, STOP and IDLE-only preset.
// All state advances on the falling edge of CLK; CLR_N is an asynchronous,
// active-low clear.
// Optional feature: define JOHNSON_ILLEGAL_RECOVER_EN to check the phase
// register for legality every edge, forcing it home and setting sticky ERR
// when it is not a valid Johnson code. Without it ERR is tied low.
// WIDTH must be at least 2.
module johnson_phase_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     CLK,
   input  logic                     CLR_N,
   johnson_phase_sequencer_if.slave bus
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]       state_q,  state_d;
   logic [WIDTH-1:0] q_q,      q_d;
   logic [CNT_W-1:0] remain_q, remain_d;
   logic             dir_q,    dir_d;
   logic             done_q,   done_d;
   logic             cmd_ready;

   // Forward: shift up, inverted MSB feeds the LSB.
   function automatic logic [WIDTH-1:0] step_fwd(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], ~v[WIDTH-1]};
   endfunction

   // Reverse: shift down, inverted LSB feeds the MSB (inverse of step_fwd).
   function automatic logic [WIDTH-1:0] step_rev(input logic [WIDTH-1:0] v);
      return {~v[0], v[WIDTH-1:1]};
   endfunction

`ifdef JOHNSON_ILLEGAL_RECOVER_EN
   logic err_q, err_d;

   // A Johnson code has at most one boundary between adjacent bits.
   function automatic logic is_legal(input logic [WIDTH-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < WIDTH - 1; i++) begin
         if (v[i] != v[i+1]) n++;
      end
      return (n <= 1);
   endfunction
`endif

   assign cmd_ready = (state_q == ST_IDLE) & ~bus.PRESET_VALID;

   // Next-state: legality recovery (if built in), then IDLE/RUN behaviour.
   always_comb begin
      state_d  = state_q;
      q_d      = q_q;
      remain_d = remain_q;
      dir_d    = dir_q;
      done_d   = 1'b0;
`ifdef JOHNSON_ILLEGAL_RECOVER_EN
      err_d    = err_q;
      if (!is_legal(q_q)) begin
         q_d      = '0;
         state_d  = ST_IDLE;
         remain_d = '0;
         err_d    = 1'b1;
      end else
`endif
      begin
         if (state_q == ST_IDLE) begin
            // STOP and HOLD have no meaning while idle; phase is kept.
            if (bus.PRESET_VALID) begin
               q_d = bus.PRESET_VAL;
            end else if (bus.CMD_VALID && cmd_ready) begin
               dir_d    = bus.CMD_DIR;
               remain_d = bus.CMD_STEPS;
               state_d  = ST_RUN;
            end
         end else begin
            if (bus.STOP) begin
               state_d  = ST_IDLE;
               remain_d = '0;
            end else if (!bus.HOLD) begin
               q_d = dir_q ? step_rev(q_q) : step_fwd(q_q);
               // A finite run never sits in RUN with REMAIN=0 (it leaves on
               // the step from 1), so REMAIN=0 here marks a continuous run.
               if (remain_q != '0) begin
                  remain_d = remain_q - CNT_W'(1);
                  if (remain_q == CNT_W'(1)) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Falling-edge state registers with asynchronous clear.
   always_ff @(negedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         state_q  <= ST_IDLE;
         q_q      <= '0;
         remain_q <= '0;
         dir_q    <= 1'b0;
         done_q   <= 1'b0;
`ifdef JOHNSON_ILLEGAL_RECOVER_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         q_q      <= q_d;
         remain_q <= remain_d;
         dir_q    <= dir_d;
         done_q   <= done_d;
`ifdef JOHNSON_ILLEGAL_RECOVER_EN
         err_q    <= err_d;
`endif
      end
   end

   assign bus.CMD_READY = cmd_ready;
   assign bus.Q         = q_q;
   assign bus.BUSY      = (state_q == ST_RUN);
   assign bus.DONE      = done_q;
   assign bus.REMAIN    = remain_q;
`ifdef JOHNSON_ILLEGAL_RECOVER_EN
   assign bus.ERR       = err_q;
`else
   assign bus.ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_phase_sequencer.sv
// Directed bench for johnson_phase_sequencer (WIDTH=4, CNT_W=8).
// Inputs change and outputs are sampled on the rising edge; the DUT
// updates on the falling edge.
module tb_johnson_phase_sequencer;

   logic clk;
   logic clr_n;
   int   total;
   int   bad;

   johnson_phase_sequencer_if #(.WIDTH(4), .CNT_W(8)) bus ();

   johnson_phase_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
      .CLK   (clk),
      .CLR_N (clr_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One DUT edge, returning at the following rising edge.
   task automatic step();
      @(negedge clk);
      @(posedge clk);
   endtask

   task automatic test_reset();
      clr_n            = 1'b0;
      bus.CMD_VALID    = 1'b0;
      bus.CMD_DIR      = 1'b0;
      bus.CMD_STEPS    = 8'd0;
      bus.PRESET_VALID = 1'b0;
      bus.PRESET_VAL   = 4'b0000;
      bus.HOLD         = 1'b0;
      bus.STOP         = 1'b0;
      @(posedge clk);
      @(posedge clk);
      total++; if (bus.Q !== 4'b0000) begin bad++; $display("FAIL rst_q got=%b exp=0000", bus.Q); end
      total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.BUSY); end
      total++; if (bus.DONE !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.DONE); end
      total++; if (bus.REMAIN !== 8'd0) begin bad++; $display("FAIL rst_remain got=%0d exp=0", bus.REMAIN); end
      total++; if (bus.ERR !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.ERR); end
      total++; if (bus.CMD_READY !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", bus.CMD_READY); end
      clr_n = 1'b1;
      step();
   endtask

   task automatic test_forward();
      logic [3:0] qe [0:2];
      logic [7:0] re [0:2];
      qe = '{4'b0001, 4'b0011, 4'b0111};
      re = '{8'd2, 8'd1, 8'd0};
      bus.CMD_VALID = 1'b1; bus.CMD_DIR = 1'b0; bus.CMD_STEPS = 8'd3;
      step();
      bus.CMD_VALID = 1'b0;
      total++; if (bus.BUSY !== 1'b1) begin bad++; $display("FAIL fwd_accept_busy got=%b exp=1", bus.BUSY); end
      total++; if (bus.REMAIN !== 8'd3) begin bad++; $display("FAIL fwd_accept_remain got=%0d exp=3", bus.REMAIN); end
      total++; if (bus.Q !== 4'b0000) begin bad++; $display("FAIL fwd_accept_q got=%b exp=0000", bus.Q); end
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (bus.Q !== qe[i]) begin bad++; $display("FAIL fwd_q[%0d] got=%b exp=%b", i, bus.Q, qe[i]); end
         total++; if (bus.REMAIN !== re[i]) begin bad++; $display("FAIL fwd_remain[%0d] got=%0d exp=%0d", i, bus.REMAIN, re[i]); end
         total++; if (bus.DONE !== (i == 2)) begin bad++; $display("FAIL fwd_done[%0d] got=%b exp=%b", i, bus.DONE, (i == 2)); end
      end
      total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL fwd_end_busy got=%b exp=0", bus.BUSY); end
      total++; if (bus.CMD_READY !== 1'b1) begin bad++; $display("FAIL fwd_done_ready got=%b exp=1", bus.CMD_READY); end
      step();
      total++; if (bus.DONE !== 1'b0) begin bad++; $display("FAIL fwd_done_clear got=%b exp=0", bus.DONE); end
      total++; if (bus.Q !== 4'b0111) begin bad++; $display("FAIL fwd_idle_q got=%b exp=0111", bus.Q); end
   endtask

   task automatic test_hold_reverse();
      logic       hv [0:6];
      logic [3:0] qe [0:6];
      logic [7:0] re [0:6];
      hv = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      qe = '{4'b0011, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b1000, 4'b1100};
      re = '{8'd4, 8'd3, 8'd3, 8'd3, 8'd2, 8'd1, 8'd0};
      bus.CMD_VALID = 1'b1; bus.CMD_DIR = 1'b1; bus.CMD_STEPS = 8'd5;
      step();
      bus.CMD_VALID = 1'b0;
      total++; if (bus.REMAIN !== 8'd5) begin bad++; $display("FAIL rev_accept_remain got=%0d exp=5", bus.REMAIN); end
      for (int i = 0; i < 7; i++) begin
         bus.HOLD = hv[i];
         step();
         total++; if (bus.Q !== qe[i]) begin bad++; $display("FAIL rev_q[%0d] got=%b exp=%b", i, bus.Q, qe[i]); end
         total++; if (bus.REMAIN !== re[i]) begin bad++; $display("FAIL rev_remain[%0d] got=%0d exp=%0d", i, bus.REMAIN, re[i]); end
         total++; if (bus.DONE !== (i == 6)) begin bad++; $display("FAIL rev_done[%0d] got=%b exp=%b", i, bus.DONE, (i == 6)); end
         total++; if (bus.BUSY !== (i != 6)) begin bad++; $display("FAIL rev_busy[%0d] got=%b exp=%b", i, bus.BUSY, (i != 6)); end
      end
      bus.HOLD = 1'b0;
      step();
   endtask

   task automatic test_continuous_stop();
      logic [3:0] qe [0:9];
      qe = '{4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000,
             4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110};
      bus.PRESET_VALID = 1'b1; bus.PRESET_VAL = 4'b0111;
      #1;
      total++; if (bus.CMD_READY !== 1'b0) begin bad++; $display("FAIL cont_preset_ready got=%b exp=0", bus.CMD_READY); end
      step();
      bus.PRESET_VALID = 1'b0;
      total++; if (bus.Q !== 4'b0111) begin bad++; $display("FAIL cont_preset_q got=%b exp=0111", bus.Q); end
      bus.CMD_VALID = 1'b1; bus.CMD_DIR = 1'b0; bus.CMD_STEPS = 8'd0;
      step();
      bus.CMD_VALID = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         total++; if (bus.Q !== qe[i]) begin bad++; $display("FAIL cont_q[%0d] got=%b exp=%b", i, bus.Q, qe[i]); end
         total++; if (bus.REMAIN !== 8'd0) begin bad++; $display("FAIL cont_remain[%0d] got=%0d exp=0", i, bus.REMAIN); end
         total++; if (bus.BUSY !== 1'b1) begin bad++; $display("FAIL cont_busy[%0d] got=%b exp=1", i, bus.BUSY); end
      end
      bus.STOP = 1'b1;
      step();
      bus.STOP = 1'b0;
      total++; if (bus.Q !== 4'b1110) begin bad++; $display("FAIL stop_q got=%b exp=1110", bus.Q); end
      total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL stop_busy got=%b exp=0", bus.BUSY); end
      total++; if (bus.DONE !== 1'b0) begin bad++; $display("FAIL stop_done got=%b exp=0", bus.DONE); end
      total++; if (bus.CMD_READY !== 1'b1) begin bad++; $display("FAIL stop_ready got=%b exp=1", bus.CMD_READY); end
      step();
      total++; if (bus.Q !== 4'b1110) begin bad++; $display("FAIL stop_idle_q got=%b exp=1110", bus.Q); end
   endtask

   task automatic test_preset_collision();
      bus.PRESET_VALID = 1'b1; bus.PRESET_VAL = 4'b1000;
      bus.CMD_VALID = 1'b1; bus.CMD_DIR = 1'b0; bus.CMD_STEPS = 8'd2;
      #1;
      total++; if (bus.CMD_READY !== 1'b0) begin bad++; $display("FAIL coll_ready got=%b exp=0", bus.CMD_READY); end
      step();
      bus.PRESET_VALID = 1'b0;
      total++; if (bus.Q !== 4'b1000) begin bad++; $display("FAIL coll_q got=%b exp=1000", bus.Q); end
      total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL coll_busy got=%b exp=0", bus.BUSY); end
      #1;
      total++; if (bus.CMD_READY !== 1'b1) begin bad++; $display("FAIL coll_ready_next got=%b exp=1", bus.CMD_READY); end
      step();
      bus.CMD_VALID = 1'b0;
      total++; if (bus.BUSY !== 1'b1) begin bad++; $display("FAIL coll_accept_busy got=%b exp=1", bus.BUSY); end
      total++; if (bus.REMAIN !== 8'd2) begin bad++; $display("FAIL coll_accept_remain got=%0d exp=2", bus.REMAIN); end
      step();
      total++; if (bus.Q !== 4'b0000) begin bad++; $display("FAIL coll_q1 got=%b exp=0000", bus.Q); end
      step();
      total++; if (bus.Q !== 4'b0001) begin bad++; $display("FAIL coll_q2 got=%b exp=0001", bus.Q); end
      total++; if (bus.DONE !== 1'b1) begin bad++; $display("FAIL coll_done got=%b exp=1", bus.DONE); end
      step();
   endtask

   task automatic test_clr_mid_run();
      bus.CMD_VALID = 1'b1; bus.CMD_DIR = 1'b0; bus.CMD_STEPS = 8'd6;
      step();
      bus.CMD_VALID = 1'b0;
      step();
      step();
      total++; if (bus.REMAIN !== 8'd4) begin bad++; $display("FAIL clr_pre_remain got=%0d exp=4", bus.REMAIN); end
      total++; if (bus.Q !== 4'b0111) begin bad++; $display("FAIL clr_pre_q got=%b exp=0111", bus.Q); end
      clr_n = 1'b0;
      #1;
      total++; if (bus.Q !== 4'b0000) begin bad++; $display("FAIL clr_q got=%b exp=0000", bus.Q); end
      total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL clr_busy got=%b exp=0", bus.BUSY); end
      total++; if (bus.REMAIN !== 8'd0) begin bad++; $display("FAIL clr_remain got=%0d exp=0", bus.REMAIN); end
      @(posedge clk);
      clr_n = 1'b1;
      step();
      total++; if (bus.DONE !== 1'b0) begin bad++; $display("FAIL clr_done got=%b exp=0", bus.DONE); end
      total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL clr_after_busy got=%b exp=0", bus.BUSY); end
      total++; if (bus.Q !== 4'b0000) begin bad++; $display("FAIL clr_after_q got=%b exp=0000", bus.Q); end
   endtask

   task automatic test_back_to_back();
      bus.CMD_VALID = 1'b1; bus.CMD_DIR = 1'b0; bus.CMD_STEPS = 8'd1;
      step();
      bus.CMD_VALID = 1'b0;
      step();
      total++; if (bus.DONE !== 1'b1) begin bad++; $display("FAIL b2b_done1 got=%b exp=1", bus.DONE); end
      total++; if (bus.Q !== 4'b0001) begin bad++; $display("FAIL b2b_q1 got=%b exp=0001", bus.Q); end
      total++; if (bus.CMD_READY !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", bus.CMD_READY); end
      bus.CMD_VALID = 1'b1; bus.CMD_DIR = 1'b1; bus.CMD_STEPS = 8'd2;
      step();
      bus.CMD_VALID = 1'b0;
      total++; if (bus.BUSY !== 1'b1) begin bad++; $display("FAIL b2b_busy2 got=%b exp=1", bus.BUSY); end
      total++; if (bus.REMAIN !== 8'd2) begin bad++; $display("FAIL b2b_remain2 got=%0d exp=2", bus.REMAIN); end
      total++; if (bus.DONE !== 1'b0) begin bad++; $display("FAIL b2b_done_clear got=%b exp=0", bus.DONE); end
      step();
      total++; if (bus.Q !== 4'b0000) begin bad++; $display("FAIL b2b_q2a got=%b exp=0000", bus.Q); end
      step();
      total++; if (bus.Q !== 4'b1000) begin bad++; $display("FAIL b2b_q2b got=%b exp=1000", bus.Q); end
      total++; if (bus.DONE !== 1'b1) begin bad++; $display("FAIL b2b_done2 got=%b exp=1", bus.DONE); end
      step();
   endtask

   task automatic test_illegal();
      bus.PRESET_VALID = 1'b1; bus.PRESET_VAL = 4'b0101;
      step();
      bus.PRESET_VALID = 1'b0;
      total++; if (bus.Q !== 4'b0101) begin bad++; $display("FAIL ill_preset_q got=%b exp=0101", bus.Q); end
`ifdef JOHNSON_ILLEGAL_RECOVER_EN
      step();
      total++; if (bus.Q !== 4'b0000) begin bad++; $display("FAIL ill_recover_q got=%b exp=0000", bus.Q); end
      total++; if (bus.ERR !== 1'b1) begin bad++; $display("FAIL ill_err got=%b exp=1", bus.ERR); end
      bus.CMD_VALID = 1'b1; bus.CMD_DIR = 1'b0; bus.CMD_STEPS = 8'd2;
      step();
      bus.CMD_VALID = 1'b0;
      step();
      total++; if (bus.Q !== 4'b0001) begin bad++; $display("FAIL ill_run_q1 got=%b exp=0001", bus.Q); end
      step();
      total++; if (bus.Q !== 4'b0011) begin bad++; $display("FAIL ill_run_q2 got=%b exp=0011", bus.Q); end
      total++; if (bus.DONE !== 1'b1) begin bad++; $display("FAIL ill_run_done got=%b exp=1", bus.DONE); end
      total++; if (bus.ERR !== 1'b1) begin bad++; $display("FAIL ill_err_sticky got=%b exp=1", bus.ERR); end
`else
      begin
         logic [3:0] qe [0:2];
         qe = '{4'b1011, 4'b0110, 4'b1101};
         bus.CMD_VALID = 1'b1; bus.CMD_DIR = 1'b0; bus.CMD_STEPS = 8'd3;
         step();
         bus.CMD_VALID = 1'b0;
         for (int i = 0; i < 3; i++) begin
            step();
            total++; if (bus.Q !== qe[i]) begin bad++; $display("FAIL ill_orbit_q[%0d] got=%b exp=%b", i, bus.Q, qe[i]); end
            total++; if (bus.ERR !== 1'b0) begin bad++; $display("FAIL ill_err_low[%0d] got=%b exp=0", i, bus.ERR); end
         end
         total++; if (bus.DONE !== 1'b1) begin bad++; $display("FAIL ill_orbit_done got=%b exp=1", bus.DONE); end
      end
`endif
      step();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_forward();
      test_hold_reverse();
      test_continuous_stop();
      test_preset_collision();
      test_clr_mid_run();
      test_back_to_back();
      test_illegal();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
